// File: rtl/phase_seq_pkg.sv
// Shared state encodings and wait-counter width for the phase sequencer.
package phase_seq_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] DECODE = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] MEM    = 3'd4;
  localparam logic [2:0] WB     = 3'd5;
  localparam logic [2:0] ERR    = 3'd6;

  localparam int unsigned WAIT_W = 8;

endpackage

// File: rtl/phase_wait_timer.sv
// MEM-phase wait counter: clear/increment, with a match flag at MEM_WAIT_MAX-1.
module phase_wait_timer
  import phase_seq_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic term
);

  localparam logic [WAIT_W-1:0] TERM_VAL = WAIT_W'(MEM_WAIT_MAX - 1);

  logic [WAIT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign term = (count_q == TERM_VAL);

endmodule

// File: rtl/phase_sequencer.sv
// One-clock multi-phase instruction sequencer with one-cycle phase enables.
// Optional single-step issue input enabled by defining PHASE_SEQ_STEP_EN.
module phase_sequencer
  import phase_seq_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
`ifdef PHASE_SEQ_STEP_EN
  input  logic             step,
`endif
  input  logic             is_mem_op,
  input  logic             dmem_ready,
  output logic             imem_en,
  output logic             regfile_rd_en,
  output logic             proc_en,
  output logic             dmem_en,
  output logic             regfile_wr_en,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] insn_count,
  output logic             timeout
);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] insn_count_q, insn_count_d;
  logic             timeout_q, timeout_d;
  logic             issue;
  logic             wait_clr;
  logic             wait_inc;
  logic             wait_term;

  // A step request only matters in IDLE, where run=1 already issues.
`ifdef PHASE_SEQ_STEP_EN
  assign issue = run | step;
`else
  assign issue = run;
`endif

  phase_wait_timer #(
    .MEM_WAIT_MAX(MEM_WAIT_MAX)
  ) u_wait_timer (
    .clock(clock),
    .reset(reset),
    .clr  (wait_clr),
    .inc  (wait_inc),
    .term (wait_term)
  );

  always_comb begin
    state_d      = state_q;
    insn_count_d = insn_count_q;
    timeout_d    = timeout_q;
    wait_clr     = 1'b0;
    wait_inc     = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue) state_d = FETCH;
      end
      FETCH:  state_d = DECODE;
      DECODE: state_d = EXEC;
      EXEC: begin
        if (is_mem_op) begin
          state_d  = MEM;
          wait_clr = 1'b1;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        wait_inc = ~dmem_ready;
        if (dmem_ready) begin
          state_d = WB;
        end else if (wait_term) begin
          state_d   = ERR;
          timeout_d = 1'b1;
        end
      end
      WB: begin
        insn_count_d = insn_count_q + CNT_W'(1);
        state_d      = run ? FETCH : IDLE;
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      insn_count_q <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      insn_count_q <= insn_count_d;
      timeout_q    <= timeout_d;
    end
  end

  always_comb begin
    imem_en       = (state_q == FETCH);
    regfile_rd_en = (state_q == DECODE);
    proc_en       = (state_q == EXEC);
    dmem_en       = (state_q == MEM);
    regfile_wr_en = (state_q == WB);
  end

  assign phase      = state_q;
  assign insn_count = insn_count_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed self-checking bench for phase_sequencer (MEM_WAIT_MAX=4, CNT_W=4).
module tb_phase_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       is_mem_op = 1'b0;
  logic       dmem_ready = 1'b0;
`ifdef PHASE_SEQ_STEP_EN
  logic       step = 1'b0;
`endif
  logic       imem_en, regfile_rd_en, proc_en, dmem_en, regfile_wr_en;
  logic [2:0] phase;
  logic [3:0] insn_count;
  logic       timeout;
  logic [4:0] strb;

  int         n_cmp = 0;
  int         n_fail = 0;
  logic [3:0] model_cnt = 4'd0;

  phase_sequencer #(
    .MEM_WAIT_MAX(4),
    .CNT_W       (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .run          (run),
`ifdef PHASE_SEQ_STEP_EN
    .step         (step),
`endif
    .is_mem_op    (is_mem_op),
    .dmem_ready   (dmem_ready),
    .imem_en      (imem_en),
    .regfile_rd_en(regfile_rd_en),
    .proc_en      (proc_en),
    .dmem_en      (dmem_en),
    .regfile_wr_en(regfile_wr_en),
    .phase        (phase),
    .insn_count   (insn_count),
    .timeout      (timeout)
  );

  always #5 clock = ~clock;

  assign strb = {imem_en, regfile_rd_en, proc_en, dmem_en, regfile_wr_en};

  function automatic logic [4:0] exp_strb(input logic [2:0] p);
    case (p)
      3'd1:    return 5'b10000;
      3'd2:    return 5'b01000;
      3'd3:    return 5'b00100;
      3'd4:    return 5'b00010;
      3'd5:    return 5'b00001;
      default: return 5'b00000;
    endcase
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({phase, strb} !== 8'h00) begin
      n_fail++; $display("FAIL reset_state phase/strb got %0d/%b want 0/00000", phase, strb);
    end
    n_cmp++;
    if (insn_count !== 4'd0 || timeout !== 1'b0) begin
      n_fail++; $display("FAIL reset_regs count/timeout got %0d/%b want 0/0", insn_count, timeout);
    end
    run = 1'b1;
    tick();
    n_cmp++;
    if (phase !== 3'd0) begin
      n_fail++; $display("FAIL reset_hold phase got %0d want 0", phase);
    end
    run = 1'b0;
    reset = 1'b1;
    tick();
    n_cmp++;
    if ({phase, strb} !== 8'h00) begin
      n_fail++; $display("FAIL idle_no_run phase/strb got %0d/%b want 0/00000", phase, strb);
    end
  endtask

  task automatic test_nonmem;
    logic [2:0] pat [4];
    logic [2:0] ep;
    pat[0] = 3'd1; pat[1] = 3'd2; pat[2] = 3'd3; pat[3] = 3'd5;
    is_mem_op = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      ep = pat[i % 4];
      n_cmp++;
      if ({phase, strb} !== {ep, exp_strb(ep)}) begin
        n_fail++; $display("FAIL nonmem_phase[%0d] phase/strb got %0d/%b want %0d/%b", i, phase, strb, ep, exp_strb(ep));
      end
      n_cmp++;
      if (insn_count !== model_cnt) begin
        n_fail++; $display("FAIL nonmem_count[%0d] got %0d want %0d", i, insn_count, model_cnt);
      end
      if (ep == 3'd5) model_cnt++;
      if (i == 11) run = 1'b0;
    end
    tick();
    n_cmp++;
    if ({phase, insn_count} !== {3'd0, 4'd3}) begin
      n_fail++; $display("FAIL nonmem_end phase/count got %0d/%0d want 0/3", phase, insn_count);
    end
  endtask

  task automatic test_mem(input int waits);
    logic [2:0] exp_q [$];
    int mem_seen;
    int en_cnt;
    exp_q = {3'd1, 3'd2, 3'd3};
    for (int k = 0; k <= waits; k++) exp_q.push_back(3'd4);
    exp_q.push_back(3'd5);
    exp_q.push_back(3'd0);
    mem_seen = 0;
    en_cnt = 0;
    is_mem_op = 1'b1;
    dmem_ready = 1'b1;
    run = 1'b1;
    foreach (exp_q[i]) begin
      tick();
      if (i == 0) run = 1'b0;
      n_cmp++;
      if ({phase, strb} !== {exp_q[i], exp_strb(exp_q[i])}) begin
        n_fail++; $display("FAIL mem%0d_phase[%0d] phase/strb got %0d/%b want %0d/%b", waits, i, phase, strb, exp_q[i], exp_strb(exp_q[i]));
      end
      if (dmem_en) en_cnt++;
      if (phase == 3'd4) begin
        mem_seen++;
        is_mem_op = 1'b0;
      end
      // ready is high (and must be ignored) during FETCH/DECODE
      dmem_ready = (phase == 3'd1 || phase == 3'd2) || (phase == 3'd4 && mem_seen == waits + 1);
    end
    model_cnt++;
    n_cmp++;
    if (en_cnt !== waits + 1) begin
      n_fail++; $display("FAIL mem%0d_dmem_en_cycles got %0d want %0d", waits, en_cnt, waits + 1);
    end
    n_cmp++;
    if ({insn_count, timeout} !== {model_cnt, 1'b0}) begin
      n_fail++; $display("FAIL mem%0d_count/timeout got %0d/%b want %0d/0", waits, insn_count, timeout, model_cnt);
    end
    dmem_ready = 1'b0;
  endtask

  task automatic test_run_drop;
    logic [2:0] exp_p [7];
    exp_p = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd0, 3'd0, 3'd0};
    is_mem_op = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      n_cmp++;
      if ({phase, strb} !== {exp_p[i], exp_strb(exp_p[i])}) begin
        n_fail++; $display("FAIL run_drop_phase[%0d] phase/strb got %0d/%b want %0d/%b", i, phase, strb, exp_p[i], exp_strb(exp_p[i]));
      end
      if (phase == 3'd2) run = 1'b0;
    end
    model_cnt++;
    n_cmp++;
    if (insn_count !== model_cnt) begin
      n_fail++; $display("FAIL run_drop_count got %0d want %0d", insn_count, model_cnt);
    end
  endtask

  task automatic test_back_to_back_wrap;
    logic [2:0] pat [4];
    int n;
    pat[0] = 3'd1; pat[1] = 3'd2; pat[2] = 3'd3; pat[3] = 3'd5;
    n = 16 - int'(model_cnt);
    is_mem_op = 1'b0;
    run = 1'b1;
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < 4; j++) begin
        tick();
        n_cmp++;
        if (phase !== pat[j]) begin
          n_fail++; $display("FAIL b2b_phase[%0d.%0d] got %0d want %0d", k, j, phase, pat[j]);
        end
      end
      n_cmp++;
      if (insn_count !== model_cnt) begin
        n_fail++; $display("FAIL b2b_count[%0d] got %0d want %0d", k, insn_count, model_cnt);
      end
      model_cnt++;
      if (k == n - 1) run = 1'b0;
    end
    tick();
    n_cmp++;
    if ({phase, insn_count} !== {3'd0, 4'd0}) begin
      n_fail++; $display("FAIL wrap_to_zero phase/count got %0d/%0d want 0/0", phase, insn_count);
    end
  endtask

`ifdef PHASE_SEQ_STEP_EN
  task automatic test_step;
    logic [2:0] exp_a [7];
    logic [2:0] exp_b [10];
    exp_a = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd0, 3'd0, 3'd0};
    exp_b = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd0};
    run = 1'b0;
    is_mem_op = 1'b0;
    step = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 0) step = 1'b0;
      n_cmp++;
      if (phase !== exp_a[i]) begin
        n_fail++; $display("FAIL step_pulse_phase[%0d] got %0d want %0d", i, phase, exp_a[i]);
      end
      if (phase == 3'd3) step = 1'b1;
      if (phase == 3'd5) step = 1'b0;
    end
    model_cnt++;
    step = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (phase !== exp_b[i]) begin
        n_fail++; $display("FAIL step_held_phase[%0d] got %0d want %0d", i, phase, exp_b[i]);
      end
      if (i == 5) step = 1'b0;
    end
    model_cnt = model_cnt + 4'd2;
    n_cmp++;
    if (insn_count !== model_cnt) begin
      n_fail++; $display("FAIL step_count got %0d want %0d", insn_count, model_cnt);
    end
  endtask
`endif

  task automatic test_async_reset;
    is_mem_op = 1'b1;
    dmem_ready = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      run = 1'b0;
    end
    n_cmp++;
    if (phase !== 3'd4) begin
      n_fail++; $display("FAIL areset_reach_mem got %0d want 4", phase);
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({phase, strb, insn_count} !== {3'd0, 5'b00000, 4'd0}) begin
      n_fail++; $display("FAIL areset_immediate phase/strb/count got %0d/%b/%0d want 0/00000/0", phase, strb, insn_count);
    end
    model_cnt = 4'd0;
    tick();
    reset = 1'b1;
    tick();
    n_cmp++;
    if (phase !== 3'd0) begin
      n_fail++; $display("FAIL areset_release got %0d want 0", phase);
    end
  endtask

  task automatic test_timeout;
    logic [2:0] exp_p [8];
    exp_p = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd6};
    is_mem_op = 1'b1;
    dmem_ready = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++;
      if ({phase, strb, timeout} !== {exp_p[i], exp_strb(exp_p[i]), (i == 7)}) begin
        n_fail++; $display("FAIL timeout_seq[%0d] phase/strb/timeout got %0d/%b/%b want %0d/%b/%b", i, phase, strb, timeout, exp_p[i], exp_strb(exp_p[i]), (i == 7));
      end
      run = 1'b0;
    end
    dmem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      run = i[0];
      tick();
      n_cmp++;
      if ({phase, strb, timeout, insn_count} !== {3'd6, 5'b00000, 1'b1, model_cnt}) begin
        n_fail++; $display("FAIL err_absorb[%0d] phase/strb/timeout/count got %0d/%b/%b/%0d want 6/00000/1/%0d", i, phase, strb, timeout, insn_count, model_cnt);
      end
    end
    run = 1'b0;
    dmem_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({phase, timeout} !== {3'd0, 1'b0}) begin
      n_fail++; $display("FAIL err_reset phase/timeout got %0d/%b want 0/0", phase, timeout);
    end
    tick();
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_mem(3);
    test_mem(1);
    test_mem(0);
    test_run_drop();
    test_back_to_back_wrap();
`ifdef PHASE_SEQ_STEP_EN
    test_step();
`endif
    test_async_reset();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
